// File: rtl/pmod_als_emu_if.sv
// SPI link between an ALS reader (master) and the PmodALS emulator (slave).
// cs/sck are generated by the reader; sdo/sdo_oe are returned by the emulator.
interface pmod_als_emu_if;
  logic cs;
  logic sck;
  logic sdo;
  logic sdo_oe;

  modport master (
    output cs,
    output sck,
    input  sdo,
    input  sdo_oe
  );

  modport slave (
    input  cs,
    input  sck,
    output sdo,
    output sdo_oe
  );
endinterface

// File: rtl/pmod_als_emu.sv
// PmodALS (ADC081S021-style) SPI responder: per chip-select, shifts out
// LEAD_ZEROS zeros, then the captured value MSB first, then zeros.
module pmod_als_emu #(
  parameter int LEAD_ZEROS = 3,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pmod_als_emu_if.slave        spi,
  input  logic [DATA_BITS-1:0] value,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_abort
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam logic [4:0] LAST_BIT_CNT = 5'(FRAME_BITS - 1);
  localparam logic [4:0] CNT_MAX      = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_TAIL
  } state_t;

  // [0],[1] synchronize; [2] is the history flop for edge detection
  logic [2:0] cs_sync_reg;
  logic [2:0] sck_sync_reg;

  state_t                  state_reg, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [4:0]              bit_cnt_reg, bit_cnt_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    frame_abort_reg, frame_abort_next;

  logic cs_fall;
  logic cs_rise;
  logic sck_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_reg  <= 3'b111;
      sck_sync_reg <= 3'b000;
    end else begin
      cs_sync_reg  <= {cs_sync_reg[1:0], spi.cs};
      sck_sync_reg <= {sck_sync_reg[1:0], spi.sck};
    end
  end

  assign cs_fall  = cs_sync_reg[2] & ~cs_sync_reg[1];
  assign cs_rise  = ~cs_sync_reg[2] & cs_sync_reg[1];
  assign sck_fall = sck_sync_reg[2] & ~sck_sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      shift_reg       <= '0;
      bit_cnt_reg     <= '0;
      frame_done_reg  <= 1'b0;
      frame_abort_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      bit_cnt_reg     <= bit_cnt_next;
      frame_done_reg  <= frame_done_next;
      frame_abort_reg <= frame_abort_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    shift_next       = shift_reg;
    bit_cnt_next     = bit_cnt_reg;
    frame_done_next  = 1'b0;
    frame_abort_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // sck edges are meaningless while deselected, so only cs_fall matters
        if (cs_fall) begin
          shift_next   = {{LEAD_ZEROS{1'b0}}, value};
          bit_cnt_next = '0;
          state_next   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // cs_rise takes priority over a coincident sck_fall
        if (cs_rise) begin
          frame_abort_next = 1'b1;
          shift_next       = '0;
          bit_cnt_next     = '0;
          state_next       = S_IDLE;
        end else if (sck_fall) begin
          shift_next   = {shift_reg[FRAME_BITS-2:0], 1'b0};
          bit_cnt_next = bit_cnt_reg + 5'd1;
          if (bit_cnt_reg == LAST_BIT_CNT) begin
            state_next = S_TAIL;
          end
        end
      end

      S_TAIL: begin
        if (cs_rise) begin
          frame_done_next = 1'b1;
          shift_next      = '0;
          bit_cnt_next    = '0;
          state_next      = S_IDLE;
        end else if (sck_fall && (bit_cnt_reg != CNT_MAX)) begin
          bit_cnt_next = bit_cnt_reg + 5'd1;
        end
      end

      default: begin
        state_next   = S_IDLE;
        shift_next   = '0;
        bit_cnt_next = '0;
      end
    endcase
  end

  // The first leading zero is presented as soon as S_SHIFT is entered
  assign spi.sdo     = (state_reg == S_SHIFT) & shift_reg[FRAME_BITS-1];
  assign spi.sdo_oe  = (state_reg != S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign frame_done  = frame_done_reg;
  assign frame_abort = frame_abort_reg;

endmodule
